// File: rtl/seq_left_shifter_if.sv
// Request/response bundle between the sequential control FSM and the
// multi-cycle left shifter.
interface seq_left_shifter_if;
  logic        start;
  logic [63:0] data_in;
  logic [5:0]  shift_amt;
  logic        word_mode;
  logic        busy;
  logic        done;
  logic [63:0] data_out;

  modport master (
    output start, data_in, shift_amt, word_mode,
    input  busy, done, data_out
  );

  modport slave (
    input  start, data_in, shift_amt, word_mode,
    output busy, done, data_out
  );
endinterface

// File: rtl/seq_left_shifter.sv
// Multi-cycle 64-bit logical left shifter (SLL/SLLW family): one shift-amount
// bit per cycle through a single shared stage, start/busy/done handshake.
module seq_left_shifter (
  input  logic                clk,
  input  logic                rst_n,
  seq_left_shifter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [5:0]  amt;
  logic        wm;
  logic [2:0]  k;
  logic        busy_q, done_q;
  logic [63:0] data_q;
  logic [63:0] stage_out;
  logic [63:0] result;

  // The one shared stage: conditional shift by 2^k selected by the counter.
  always_comb begin
    stage_out = acc;
    case (k)
      3'd0: if (amt[0]) stage_out = {acc[62:0], 1'b0};
      3'd1: if (amt[1]) stage_out = {acc[61:0], 2'b0};
      3'd2: if (amt[2]) stage_out = {acc[59:0], 4'b0};
      3'd3: if (amt[3]) stage_out = {acc[55:0], 8'b0};
      3'd4: if (amt[4]) stage_out = {acc[47:0], 16'b0};
      3'd5: if (amt[5]) stage_out = {acc[31:0], 32'b0};
      default: stage_out = acc;
    endcase
  end

  assign result = wm ? {{32{stage_out[31]}}, stage_out[31:0]} : stage_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      amt    <= '0;
      wm     <= 1'b0;
      k      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc    <= bus.data_in;
            // W-forms only honour a 5-bit count
            amt    <= {bus.shift_amt[5] & ~bus.word_mode, bus.shift_amt[4:0]};
            wm     <= bus.word_mode;
            k      <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          acc <= stage_out;
          k   <= k + 3'd1;
          if (k == 3'd5) begin
            data_q <= result;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed bench for seq_left_shifter: vector table plus hand-written
// sequences for start-while-busy, mid-operation reset and back-to-back.
module tb_seq_left_shifter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_left_shifter_if bus ();
  seq_left_shifter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [63:0] data;
    logic [5:0]  amt;
    logic        wm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start one op, check latency, busy width, result and done width.
  task automatic run_op(input string name, input logic [63:0] d, input logic [5:0] a,
                        input logic w, input logic [63:0] exp);
    int lat;
    int busyc;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = d; bus.shift_amt = a; bus.word_mode = w;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busyc = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busyc++;
    end
    chk({name, " latency"}, 64'(lat), 64'd6);
    chk({name, " busy_cycles"}, 64'(busyc), 64'd6);
    chk({name, " data_out"}, bus.data_out, exp);
    @(negedge clk);
    chk({name, " done_width"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h1,                  6'd63, 1'b0, 64'h8000000000000000};
    vecs[1] = '{64'hDEADBEEFCAFEF00D,   6'd0,  1'b0, 64'hDEADBEEFCAFEF00D};
    vecs[2] = '{64'hDEADBEEFCAFEF00D,   6'd13, 1'b0, 64'hB7DDF95FDE01A000};
    vecs[3] = '{64'hFFFF000040000001,   6'd1,  1'b1, 64'hFFFFFFFF80000002};
    vecs[4] = '{64'hFFFF000040000001,   6'd33, 1'b1, 64'hFFFFFFFF80000002};
    vecs[5] = '{64'h1,                  6'd4,  1'b1, 64'h0000000000000010};
    vecs[6] = '{64'hFFFFFFFFFFFFFFFF,   6'd32, 1'b0, 64'hFFFFFFFF00000000};
    vecs[7] = '{64'h1234567800000001,   6'd31, 1'b1, 64'hFFFFFFFF80000000};

    bus.start = 1'b0; bus.data_in = '0; bus.shift_amt = '0; bus.word_mode = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset data_out", bus.data_out, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].wm, vecs[i].exp);

    // start pulsed with a different operand two cycles into SHIFT
    begin
      int dones;
      @(negedge clk);
      bus.start = 1'b1; bus.data_in = 64'h00000000000000FF; bus.shift_amt = 6'd8; bus.word_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 14; c++) begin
        if (c == 2) begin
          bus.start = 1'b1; bus.data_in = 64'hAAAAAAAAAAAAAAAA; bus.shift_amt = 6'd1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        if (bus.done) begin
          dones++;
          chk("busy_ignore done_time", 64'(c), 64'd6);
          chk("busy_ignore data_out", bus.data_out, 64'h000000000000FF00);
        end
      end
      chk("busy_ignore done_count", 64'(dones), 64'd1);
    end

    // reset while k=3
    begin
      int dones;
      @(negedge clk);
      bus.start = 1'b1; bus.data_in = 64'h5; bus.shift_amt = 6'd2; bus.word_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset busy", 64'(bus.busy), 64'd0);
      chk("midreset done", 64'(bus.done), 64'd0);
      chk("midreset data_out", bus.data_out, 64'd0);
      rst_n = 1'b1;
      dones = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      chk("midreset no_done", 64'(dones), 64'd0);
      run_op("post_reset", 64'h5, 6'd2, 1'b0, 64'h14);
    end

    // back-to-back: start held high into DONE
    begin
      @(negedge clk);
      bus.start = 1'b1; bus.data_in = 64'h3; bus.shift_amt = 6'd60; bus.word_mode = 1'b0;
      @(negedge clk);
      bus.data_in = 64'h80000001; bus.shift_amt = 6'd3; bus.word_mode = 1'b1;
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        if (c == 7) begin
          chk("b2b second_accept busy", 64'(bus.busy), 64'd1);
          bus.start = 1'b0;
        end
        chk($sformatf("b2b done@%0d", c), 64'(bus.done), 64'((c == 6) || (c == 13)));
        if (c == 6)  chk("b2b data_out first",  bus.data_out, 64'h3000000000000000);
        if (c == 13) chk("b2b data_out second", bus.data_out, 64'h0000000000000008);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_left_shifter.md
# seq_left_shifter

Multi-cycle 64-bit logical left shifter for the sequential RV64 datapath. It is the left-shift counterpart of the combinational arithmetic right shifter and serves SLL/SLLI and, in word mode, SLLW/SLLIW. It resolves one shift-amount bit per cycle through a single shared 64-bit stage, with a start/busy/done handshake toward the sequential control FSM. This trades six cycles of latency for one stage of shift logic.

## Interface
- No parameters; width fixed at 64 bits, shift amount fixed at 6 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; synchronous, active-low.
- start  input  1  request; sampled only when the block is not busy.
- data_in  input  64  operand; captured on the accepting edge.
- shift_amt  input  6  shift count; captured on the accepting edge.
- word_mode  input  1  1 = RV64 W-form (32-bit shift, sign-extended result); captured on the accepting edge.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when data_out is updated.
- data_out  output  64  result register; holds its value until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- Registers: acc[63:0], amt[5:0], wm, stage counter k[2:0].
- IDLE or DONE with start=1: capture acc=data_in, amt=shift_amt, wm=word_mode, k=0, then go to SHIFT.
- If wm=1, amt[5] is forced to 0 at capture, so only shift_amt[4:0] is used.
- DONE with start=0: go to IDLE.
- SHIFT, each cycle:
  - If amt[k]=1: acc <= acc << 2^k, zero-fill from the LSB, discard bits above 63.
  - Otherwise acc is unchanged.
  - k increments each cycle.
- SHIFT at k=5: apply stage 5, write data_out, go to DONE.
- Result written to data_out:
  - wm=0: the full shifted acc.
  - wm=1: {32{acc[31]}, acc[31:0]}, where acc[31] is the post-shift value. The upper operand bits never affect the result.
- start in SHIFT is ignored: no capture, no queuing, and the in-flight operation is unaffected.
- shift_amt=0 passes the operand through unchanged, with the same latency; there is no early exit.
- No saturation case exists: a 6-bit amount covers 0..63.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, data_out=0, acc=0, amt=0, wm=0, k=0.
- Reset in any state, including mid-SHIFT, aborts the operation. No done pulse follows.
- Define E0 as the edge that accepts start. Edges E1..E6 perform stages 0..5.
- busy=1 during the cycles following edges E0..E5.
- done=1 and data_out valid in the cycle following E6, i.e. latency is 6 cycles from the accepting edge.
- busy=0 in DONE, so a new start can be accepted at E7.
- Back-to-back operation gives one result every 7 cycles. The second start is accepted in DONE, so done is high for exactly one cycle each time and busy rises again after E7.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Max shift: data_in=0x1, shift_amt=63, word_mode=0 -> done 6 cycles after the accepting edge; data_out=0x8000000000000000; busy high for exactly 6 cycles.
- Zero shift and mixed bits:
  - data_in=0xDEADBEEFCAFEF00D, shift_amt=0 -> data_out=0xDEADBEEFCAFEF00D.
  - shift_amt=13 -> data_out=0xB7DDF95FDE01A000.
- Word mode:
  - data_in=0xFFFF000040000001, shift_amt=1, word_mode=1 -> data_out=0xFFFFFFFF80000002.
  - shift_amt=33 (bit 5 ignored) -> same result.
  - data_in=0x1, shift_amt=4 -> 0x0000000000000010.
- Start while busy: raise start with a different operand 2 cycles into SHIFT -> ignored; the original result appears on schedule with a single done pulse.
- Reset mid-operation: drive rst_n=0 during k=3 -> busy=0, done=0, data_out=0 on the next edge, and no done afterwards. A fresh start after release completes normally.
- Back-to-back: hold start=1 with a new operand through DONE -> second operation accepted at E7; the two done pulses are 7 cycles apart, each 1 cycle wide, each with the correct data_out.
